// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: ALU funct codes, B-operand selects,
// multiply/divide FSM encodings and helpers used by the execute stage.
package mips_pipe_pkg;

  localparam int unsigned MD_CYCLES_DEF = 32;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_SLLV  = 6'h04;
  localparam logic [5:0] OP_SRLV  = 6'h06;
  localparam logic [5:0] OP_SRAV  = 6'h07;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  localparam logic [2:0] SRC_REG  = 3'd0;
  localparam logic [2:0] SRC_SIMM = 3'd1;
  localparam logic [2:0] SRC_ZIMM = 3'd2;

  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B
  function automatic logic is_md_op(input logic [5:0] op);
    return op[5:2] == 4'b0110;
  endfunction

  // Every instruction that touches HI/LO or the multiply/divide unit
  function automatic logic is_hilo_op(input logic [5:0] op);
    return (op[5:2] == 4'b0100) || (op[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit with the HI/LO registers.
// One iteration per cycle; signed operations run on magnitudes with a sign fix-up.
module ex_muldiv
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mt_hi,
  input  logic        mt_lo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = $clog2(MD_CYCLES);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   acc;
  logic [31:0]   work;
  logic [31:0]   dvs;
  logic          is_div;
  logic          neg_res;
  logic          neg_rem;
  logic          div0;
  logic [31:0]   a_raw;

  logic          sa;
  logic          sb;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [32:0]   mul_sum;
  logic [32:0]   div_sh;
  logic [32:0]   div_diff;
  logic [31:0]   acc_nxt;
  logic [31:0]   work_nxt;
  logic [63:0]   prod;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  // md_op[0] = unsigned, md_op[1] = divide
  assign sa    = ~md_op[0] & a[31];
  assign sb    = ~md_op[0] & b[31];
  assign mag_a = sa ? (~a + 32'd1) : a;
  assign mag_b = sb ? (~b + 32'd1) : b;
  assign busy  = (state == MD_BUSY);

  // Multiply: acc:work shifts right, adding dvs when the multiplier LSB is set.
  // Divide: acc:work shifts left, restoring subtraction of dvs from acc.
  always_comb begin
    mul_sum  = {1'b0, acc} + (work[0] ? {1'b0, dvs} : 33'd0);
    div_sh   = {acc, work[31]};
    div_diff = div_sh - {1'b0, dvs};
    acc_nxt  = mul_sum[32:1];
    work_nxt = {mul_sum[0], work[31:1]};
    if (is_div) begin
      if (!div_diff[32]) begin
        acc_nxt  = div_diff[31:0];
        work_nxt = {work[30:0], 1'b1};
      end else begin
        acc_nxt  = div_sh[31:0];
        work_nxt = {work[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod   = {acc_nxt, work_nxt};
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_lo = neg_res ? (~work_nxt + 32'd1) : work_nxt;
      res_hi = neg_rem ? (~acc_nxt + 32'd1) : acc_nxt;
      if (div0) begin
        res_lo = '1;
        res_hi = a_raw;
      end
    end else if (neg_res) begin
      prod   = ~prod + 64'd1;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      acc     <= '0;
      work    <= '0;
      dvs     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      a_raw   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state   <= MD_BUSY;
            cnt     <= '0;
            acc     <= '0;
            work    <= mag_a;
            dvs     <= mag_b;
            is_div  <= md_op[1];
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            div0    <= (b == '0);
            a_raw   <= a;
          end else begin
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
          end
        end
        default: begin
          acc  <= acc_nxt;
          work <= work_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(MD_CYCLES - 1)) begin
            state <= MD_IDLE;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, integer ALU and optional HI/LO unit.
// Define EX_MULDIV_EN to include ex_muldiv, HI/LO and stall generation.
module ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        reg_wr_i,
  input  logic        mem_to_reg_i,
  input  logic        mem_wr_i,
  input  logic [5:0]  alu_op_i,
  input  logic [2:0]  alu_src_i,
  input  logic        reg_dst_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] r_data_p1_i,
  input  logic [31:0] r_data_p2_i,
  input  logic [31:0] sign_imm_i,
  input  logic [5:0]  shamt_i,
  input  logic        mem_reg_wr_i,
  input  logic [4:0]  mem_wr_reg_i,
  input  logic [31:0] mem_result_i,
  input  logic        wb_reg_wr_i,
  input  logic [4:0]  wb_wr_reg_i,
  input  logic [31:0] wb_result_i,
  output logic        valid_o,
  output logic        reg_wr_o,
  output logic        mem_to_reg_o,
  output logic        mem_wr_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] wr_data_o,
  output logic [4:0]  wr_reg_o,
  output logic        overflow_o,
  output logic        stall_o,
  output logic        md_busy_o
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] opb;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic        unused_shamt;

  assign unused_shamt = shamt_i[5];

  // Memory stage is applied last so it wins over writeback
  always_comb begin
    fwd_a = r_data_p1_i;
    if (wb_reg_wr_i && (wb_wr_reg_i == rs_i) && (rs_i != 5'd0))
      fwd_a = wb_result_i;
    if (mem_reg_wr_i && (mem_wr_reg_i == rs_i) && (rs_i != 5'd0))
      fwd_a = mem_result_i;

    fwd_b = r_data_p2_i;
    if (wb_reg_wr_i && (wb_wr_reg_i == rt_i) && (rt_i != 5'd0))
      fwd_b = wb_result_i;
    if (mem_reg_wr_i && (mem_wr_reg_i == rt_i) && (rt_i != 5'd0))
      fwd_b = mem_result_i;
  end

  always_comb begin
    case (alu_src_i)
      SRC_SIMM: opb = sign_imm_i;
      SRC_ZIMM: opb = {16'h0000, sign_imm_i[15:0]};
      default:  opb = fwd_b;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic [31:0] hi;
  logic [31:0] lo;

  ex_muldiv #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (valid_o & is_md_op(alu_op_i)),
    .md_op (alu_op_i[1:0]),
    .a     (fwd_a),
    .b     (fwd_b),
    .mt_hi (valid_o & (alu_op_i == OP_MTHI)),
    .mt_lo (valid_o & (alu_op_i == OP_MTLO)),
    .busy  (md_busy_o),
    .hi    (hi),
    .lo    (lo)
  );

  assign stall_o = valid_i & md_busy_o & is_hilo_op(alu_op_i);
`else
  logic unused_md;

  assign unused_md = ^{clk, reset, 32'(MD_CYCLES)};
  assign stall_o   = 1'b0;
  assign md_busy_o = 1'b0;
`endif

  assign sum  = fwd_a + opb;
  assign diff = fwd_a - opb;

  always_comb begin
    alu_res    = '0;
    overflow_o = 1'b0;
    case (alu_op_i)
      OP_ADD: begin
        alu_res    = sum;
        overflow_o = (fwd_a[31] == opb[31]) && (sum[31] != fwd_a[31]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res    = diff;
        overflow_o = (fwd_a[31] != opb[31]) && (diff[31] != fwd_a[31]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = fwd_a & opb;
      OP_OR:   alu_res = fwd_a | opb;
      OP_XOR:  alu_res = fwd_a ^ opb;
      OP_NOR:  alu_res = ~(fwd_a | opb);
      OP_SLT:  alu_res = {31'd0, $signed(fwd_a) < $signed(opb)};
      OP_SLTU: alu_res = {31'd0, fwd_a < opb};
      OP_SLL:  alu_res = opb << shamt_i[4:0];
      OP_SRL:  alu_res = opb >> shamt_i[4:0];
      OP_SRA:  alu_res = $signed(opb) >>> shamt_i[4:0];
      OP_SLLV: alu_res = opb << fwd_a[4:0];
      OP_SRLV: alu_res = opb >> fwd_a[4:0];
      OP_SRAV: alu_res = $signed(opb) >>> fwd_a[4:0];
      OP_LUI:  alu_res = {opb[15:0], 16'h0000};
`ifdef EX_MULDIV_EN
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
`endif
      default: alu_res = '0;
    endcase
  end

  assign valid_o      = valid_i & ~stall_o;
  assign reg_wr_o     = reg_wr_i & valid_o & ~overflow_o;
  assign mem_to_reg_o = mem_to_reg_i & valid_o;
  assign mem_wr_o     = mem_wr_i & valid_o;
  assign alu_result_o = alu_res;
  assign wr_data_o    = fwd_b;
  assign wr_reg_o     = reg_dst_i ? rd_i : rt_i;

endmodule
